// File: rtl/mem_prio_arbiter.sv
// mem_prio_arbiter: priority memory-port arbiter with starvation guard and in-order response routing (MEM_ARB_PERF_EN adds perf counters)
module mem_prio_arbiter #(
  parameter int CNT          = 2,
  parameter int PRIO_IDX     = 1,
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int REQ_W        = 32,
  parameter int RESP_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CNT-1:0]                 master_req_valid,
  output logic [CNT-1:0]                 master_req_ready,
  input  logic [CNT-1:0][REQ_W-1:0]      master_req_data,
  output logic [CNT-1:0]                 master_resp_valid,
  input  logic [CNT-1:0]                 master_resp_ready,
  output logic [CNT-1:0][RESP_W-1:0]     master_resp_data,
  output logic                           slave_req_valid,
  input  logic                           slave_req_ready,
  output logic [REQ_W-1:0]               slave_req_data,
  input  logic                           slave_resp_valid,
  output logic                           slave_resp_ready,
  input  logic [RESP_W-1:0]              slave_resp_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [CNT-1:0][31:0]           perf_grants,
  output logic [31:0]                    perf_full_stall
`endif
);
  localparam int IW = CNT > 1 ? $clog2(CNT) : 1;
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [IW-1:0] PRIO = IW'(PRIO_IDX);
  localparam logic [IW-1:0] RR_INIT = IW'(PRIO_IDX == 0 ? 1 : 0);
  logic [IW-1:0] fifo [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic          lock, others_valid, issue, empty, push, pop;
  logic [IW-1:0] lock_idx, rr_ptr, rr_pick, rr_next, free_g, g, h;
  int            pick_dist, next_dist;
  assign others_valid = |(master_req_valid & ~(CNT'(1) << PRIO_IDX));
  // Distance-based search avoids variable-offset indexing: smallest wrap distance wins.
  always_comb begin
    rr_pick = PRIO;
    rr_next = RR_INIT;
    pick_dist = CNT;
    next_dist = CNT;
    for (int j = 0; j < CNT; j++) begin
      if (j != PRIO_IDX && master_req_valid[j] && (j - int'(rr_ptr) + CNT) % CNT < pick_dist) begin
        pick_dist = (j - int'(rr_ptr) + CNT) % CNT;
        rr_pick = IW'(j);
      end
      if (j != PRIO_IDX && (j - int'(g) - 1 + 2 * CNT) % CNT < next_dist) begin
        next_dist = (j - int'(g) - 1 + 2 * CNT) % CNT;
        rr_next = IW'(j);
      end
    end
  end
  assign free_g = master_req_valid[PRIO] && (starve < SW'(STARVE_LIMIT) || !others_valid) ? PRIO : rr_pick;
  assign g = lock ? lock_idx : free_g;
  assign issue = !rst && count < CW'(QUEUE_DEPTH);
  assign slave_req_valid = master_req_valid[g] && issue;
  assign slave_req_data = master_req_data[g];
  assign master_req_ready = slave_req_ready && issue ? CNT'(1) << g : '0;
  assign push = slave_req_valid && slave_req_ready;
  assign empty = rst || count == '0;
  assign h = fifo[rd_ptr];
  assign master_resp_valid = slave_resp_valid && !empty ? CNT'(1) << h : '0;
  assign master_resp_data = {CNT{slave_resp_data}};
  assign slave_resp_ready = master_resp_ready[h] && !empty;
  assign pop = slave_resp_valid && slave_resp_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
      rr_ptr <= RR_INIT;
      starve <= '0;
    end else begin
      lock <= slave_req_valid && !slave_req_ready;
      if (slave_req_valid && !slave_req_ready) lock_idx <= g;
      if (push) begin
        wr_ptr <= wr_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        if (g == PRIO) starve <= !others_valid ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + 1'b1;
        else begin
          starve <= '0;
          rr_ptr <= rr_next;
        end
      end
      if (pop) rd_ptr <= rd_ptr == PW'(QUEUE_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) if (push) fifo[wr_ptr] <= g;
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_grants <= '0;
      perf_full_stall <= '0;
    end else begin
      if (push) perf_grants[g] <= perf_grants[g] + 32'd1;
      if (|master_req_valid && count == CW'(QUEUE_DEPTH)) perf_full_stall <= perf_full_stall + 32'd1;
    end
  end
`endif
  assert property (@(posedge clk) disable iff (rst) !(slave_resp_valid && count == '0))
    else $error("memory response with no outstanding request");
endmodule

// File: tb/tb_mem_prio_arbiter.sv
// tb_mem_prio_arbiter: directed scoreboard bench for mem_prio_arbiter (CNT=2, PRIO_IDX=1, depth 2, limit 4)
module tb_mem_prio_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mrv, mrr, mpv, mpr;
  logic [1:0][31:0] mrd, mpd;
  logic srv, srr, spv, spr;
  logic [31:0] srd, spd;
`ifdef MEM_ARB_PERF_EN
  logic [1:0][31:0] pg;
  logic [31:0] pfs;
`endif
  int total = 0, bad = 0;
  int exp_g[2] = '{0, 0};
  int seq[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  typedef struct {logic id; logic [31:0] d;} exp_t;
  exp_t sb[$];

  mem_prio_arbiter #(.CNT(2), .PRIO_IDX(1), .QUEUE_DEPTH(2), .STARVE_LIMIT(4), .REQ_W(32), .RESP_W(32)) dut (
    .clk(clk), .rst(rst),
    .master_req_valid(mrv), .master_req_ready(mrr), .master_req_data(mrd),
    .master_resp_valid(mpv), .master_resp_ready(mpr), .master_resp_data(mpd),
    .slave_req_valid(srv), .slave_req_ready(srr), .slave_req_data(srd),
    .slave_resp_valid(spv), .slave_resp_ready(spr), .slave_resp_data(spd)
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg), .perf_full_stall(pfs)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fire(string tag, logic id, logic [31:0] rq, logic [31:0] rs);
    chk({tag, "_valid"}, 64'(srv), 64'(1'b1));
    chk({tag, "_data"}, 64'(srd), 64'(rq));
    chk({tag, "_grant"}, 64'(mrr), 64'(id ? 2'b10 : 2'b01));
    sb.push_back('{id, rs});
    exp_g[id]++;
  endtask

  task automatic resp(string tag);
    exp_t e;
    chk({tag, "_sb"}, 64'(sb.size() != 0), 64'(1'b1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_route"}, 64'(mpv), 64'(e.id ? 2'b10 : 2'b01));
      chk({tag, "_data"}, 64'(mpd[e.id]), 64'(e.d));
      chk({tag, "_ready"}, 64'(spr), 64'(1'b1));
    end
  endtask

  initial begin
    mrv = '0; mpr = '0; mrd = '0; srr = 1'b0; spv = 1'b0; spd = '0;
    @(negedge clk); #1;
    chk("rst_srv", 64'(srv), 64'(1'b0));
    chk("rst_mrr", 64'(mrr), 64'(2'b00));
    chk("rst_mpv", 64'(mpv), 64'(2'b00));
    chk("rst_spr", 64'(spr), 64'(1'b0));
    rst = 1'b0;
    // single requester, one-cycle memory latency
    @(negedge clk); mrv = 2'b01; mrd[0] = 32'h8000_0000; srr = 1'b1; mpr = 2'b11;
    #1 fire("t1_req", 1'b0, 32'h8000_0000, 32'h0000_0013);
    @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'h0000_0013;
    #1 resp("t1_resp");
    // both requesting continuously: four priority grants then one starvation grant
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mrv = 2'b11; mrd[0] = 32'hA000 + 32'(i); mrd[1] = 32'hB000 + 32'(i);
      spv = i > 0; spd = 32'hC000 + 32'(i) - 32'd1;
      #1;
      if (i > 0) resp($sformatf("t2_resp%0d", i));
      fire($sformatf("t2_req%0d", i), seq[i] != 0, seq[i] != 0 ? 32'hB000 + 32'(i) : 32'hA000 + 32'(i), 32'hC000 + 32'(i));
    end
    @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'hC009;
    #1 resp("t2_resp10");
    // slave stalls: locked request must stay put while priority requester arrives
    @(negedge clk); spv = 1'b0; mrv = 2'b01; mrd[0] = 32'hD0; srr = 1'b0;
    #1 chk("t3_c0_valid", 64'(srv), 64'(1'b1));
    chk("t3_c0_data", 64'(srd), 64'(32'hD0));
    chk("t3_c0_ready", 64'(mrr), 64'(2'b00));
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); mrv = 2'b11; mrd[1] = 32'hD1;
      #1 chk($sformatf("t3_c%0d_data", k), 64'(srd), 64'(32'hD0));
      chk($sformatf("t3_c%0d_ready", k), 64'(mrr), 64'(2'b00));
    end
    @(negedge clk); srr = 1'b1;
    #1 fire("t3_r0", 1'b0, 32'hD0, 32'hE0);
    @(negedge clk); mrv = 2'b10;
    #1 fire("t3_r1", 1'b1, 32'hD1, 32'hE1);
    @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'hE0;
    #1 resp("t3_resp0");
    @(negedge clk); spd = 32'hE1;
    #1 resp("t3_resp1");
    // routing FIFO full blocks issue until a response drains it
    @(negedge clk); spv = 1'b0; mrv = 2'b01; mrd[0] = 32'hF0;
    #1 fire("t4_r0", 1'b0, 32'hF0, 32'h100);
    @(negedge clk); mrd[0] = 32'hF1;
    #1 fire("t4_r1", 1'b0, 32'hF1, 32'h101);
    @(negedge clk); mrd[0] = 32'hF2;
    #1 chk("t4_full_valid", 64'(srv), 64'(1'b0));
    chk("t4_full_ready", 64'(mrr), 64'(2'b00));
    @(negedge clk); spv = 1'b1; spd = 32'h100;
    #1 chk("t4_pop_valid", 64'(srv), 64'(1'b0));
    resp("t4_resp0");
    @(negedge clk); spv = 1'b0;
    #1 fire("t4_r2", 1'b0, 32'hF2, 32'h102);
`ifdef MEM_ARB_PERF_EN
    chk("t4_perf_stall", 64'(pfs), 64'(32'd2));
`endif
    @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'h101;
    #1 resp("t4_resp1");
    @(negedge clk); spd = 32'h102;
    #1 resp("t4_resp2");
    // head requester back-pressure holds the response stream in order
    @(negedge clk); spv = 1'b0; mrv = 2'b01; mrd[0] = 32'h50;
    #1 fire("t5_r0", 1'b0, 32'h50, 32'h200);
    @(negedge clk); mrv = 2'b10; mrd[1] = 32'h51;
    #1 fire("t5_r1", 1'b1, 32'h51, 32'h201);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'h200; mpr = 2'b10;
      #1 chk($sformatf("t5_hold%0d_ready", k), 64'(spr), 64'(1'b0));
      chk($sformatf("t5_hold%0d_route", k), 64'(mpv), 64'(2'b01));
    end
    @(negedge clk); mpr = 2'b11;
    #1 resp("t5_resp0");
    @(negedge clk); spd = 32'h201;
    #1 resp("t5_resp1");
    // async reset with two requests outstanding
    @(negedge clk); spv = 1'b0; mrv = 2'b01; mrd[0] = 32'h60;
    #1 chk("t6_pre0", 64'(srv), 64'(1'b1));
    @(negedge clk); mrv = 2'b10; mrd[1] = 32'h61;
    #1 chk("t6_pre1", 64'(srv), 64'(1'b1));
    @(negedge clk); mrv = 2'b01;
    #1 chk("t6_full", 64'(srv), 64'(1'b0));
    #1 rst = 1'b1; exp_g = '{0, 0};
    #1 chk("t6_rst_srv", 64'(srv), 64'(1'b0));
    chk("t6_rst_mrr", 64'(mrr), 64'(2'b00));
    spv = 1'b1; spd = 32'hDEAD;
    #1 chk("t6_rst_spr", 64'(spr), 64'(1'b0));
    chk("t6_rst_mpv", 64'(mpv), 64'(2'b00));
    @(negedge clk); rst = 1'b0; spv = 1'b0; mrd[0] = 32'h70;
    #1 fire("t6_r0", 1'b0, 32'h70, 32'h300);
    @(negedge clk); mrd[0] = 32'h71;
    #1 fire("t6_r1", 1'b0, 32'h71, 32'h301);
    @(negedge clk); mrv = 2'b00; spv = 1'b1; spd = 32'h300;
    #1 resp("t6_resp0");
    @(negedge clk); spd = 32'h301;
    #1 resp("t6_resp1");
    @(negedge clk); spv = 1'b0;
    #1 chk("sb_drained", 64'(sb.size()), 64'(0));
    chk("idle_spr", 64'(spr), 64'(1'b0));
`ifdef MEM_ARB_PERF_EN
    chk("perf_g0", 64'(pg[0]), 64'(exp_g[0]));
    chk("perf_g1", 64'(pg[1]), 64'(exp_g[1]));
    chk("perf_stall_rst", 64'(pfs), 64'(32'd0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
